// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
//   Registered, parametrised Hack-style ALU with a valid/ready handshake on
//   both sides and a one-entry output register. The full zx/nx/zy/ny/f/no
//   function is computed generically, so every one of the 64 control codes
//   has a defined result. It also produces carry and signed-overflow flags.
//
//   Optional feature (compile-time macro ALU_MUL_EN):
//     defined   - in_mul = 1 on an accepted request starts an iterative
//                 shift-add multiply. The multiply takes WIDTH cycles in
//                 MUL, then waits in MWAIT for the output register to be
//                 free. ctrl is ignored for that op.
//     undefined - in_mul is ignored. Every op is a latency-1 ALU op.
//
// Parameters
//   WIDTH      datapath width in bits (>= 4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready
//   x, y       operands
//   ctrl       {zx,nx,zy,ny,f,no}
//   in_mul     multiply request (only honoured with ALU_MUL_EN)
//   out_valid  result valid
//   out_ready  result consumed when out_valid && out_ready
//   out        result
//   zr         out == 0
//   ng         out[WIDTH-1]
//   cy         carry out of the adder (f = 1), or product overflowed WIDTH
//   ov         signed overflow of the adder (f = 1)
// ----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             in_mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    MWAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
  logic unused_in_mul;
  assign unused_in_mul = in_mul;
`endif

  // ALU datapath
  logic             zx, nx, zy, ny, f, no;
  logic [WIDTH-1:0] x1, x2, y1, y2, alu_r, alu_res;
  logic [WIDTH:0]   alu_sum;
  logic             alu_cy, alu_ov;

  assign {zx, nx, zy, ny, f, no} = ctrl;

  always_comb begin
    x1      = zx ? '0 : x;
    x2      = nx ? ~x1 : x1;
    y1      = zy ? '0 : y;
    y2      = ny ? ~y1 : y1;
    alu_sum = {1'b0, x2} + {1'b0, y2};
    alu_r   = f ? alu_sum[WIDTH-1:0] : (x2 & y2);
    alu_res = no ? ~alu_r : alu_r;
    // Flags describe the adder, so they are taken before the optional
    // output inversion and are forced low for the AND function.
    alu_cy  = f & alu_sum[WIDTH];
    alu_ov  = f & (x2[WIDTH-1] == y2[WIDTH-1]) &
              (alu_sum[WIDTH-1] != x2[WIDTH-1]);
  end

  // Handshake
  logic out_free;
  logic accept;

  // The output register can take a new value if it is empty or its current
  // value is being consumed this very cycle, which gives back-to-back ops
  // with no bubble.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = rst_n && (state_q == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Next-state logic
  logic             load;
  logic [WIDTH-1:0] res_val;
  logic             res_cy;
  logic             res_ov;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    cy_d        = cy_q;
    ov_d        = ov_q;
`ifdef ALU_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
`endif
    load        = 1'b0;
    res_val     = alu_res;
    res_cy      = alu_cy;
    res_ov      = alu_ov;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (in_mul) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, x};
            mplier_d = y;
            prod_d   = '0;
            cnt_d    = '0;
          end else
`endif
          load = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        // One shift-add step per cycle, LSB of the multiplier first.
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MWAIT;
        end
      end
      MWAIT: begin
        if (out_free) begin
          load    = 1'b1;
          res_val = prod_q[WIDTH-1:0];
          res_cy  = |prod_q[2*WIDTH-1:WIDTH];
          res_ov  = 1'b0;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_d       = res_val;
      zr_d        = (res_val == '0);
      ng_d        = res_val[WIDTH-1];
      cy_d        = res_cy;
      ov_d        = res_ov;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
`ifdef ALU_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cy        = cy_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
//   Directed testbench for alu_seq. Drives a WIDTH=16 instance for most
//   scenarios and a WIDTH=8 instance for the narrow-datapath checks.
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   at the same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        in_mul;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng, cy, ov;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  x8;
  logic [7:0]  y8;
  logic [5:0]  ctrl8;
  logic        in_mul8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out8;
  logic        zr8, ng8, cy8, ov8;

  int checks;
  int errors;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .in_mul    (in_mul),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .cy        (cy),
    .ov        (ov)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .x         (x8),
    .y         (y8),
    .ctrl      (ctrl8),
    .in_mul    (in_mul8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out       (out8),
    .zr        (zr8),
    .ng        (ng8),
    .cy        (cy8),
    .ov        (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset; every output must be cleared without a clock edge.
  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    x          = '0;
    y          = '0;
    ctrl       = '0;
    in_mul     = 1'b0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    x8         = '0;
    y8         = '0;
    ctrl8      = '0;
    in_mul8    = 1'b0;
    out_ready8 = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    checks++;
    if ({out, zr, ng, cy, ov} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got out=%h zr=%b ng=%b cy=%b ov=%b, expected all 0", out, zr, ng, cy, ov);
    end
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b0 || out8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_w8: got out_valid=%b in_ready=%b out=%h, expected 0 0 00", out_valid8, in_ready8, out8);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
  endtask

  // 3 + 5 with latency 1, then the result drains.
  task automatic test_add();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 16'd3;
    y         = 16'd5;
    ctrl      = 6'b000010;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL add_result: got valid=%b out=%h, expected 1 0008", out_valid, out);
    end
    checks++;
    if ({zr, ng, cy, ov} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL add_flags: got zr/ng/cy/ov=%b%b%b%b, expected 0000", zr, ng, cy, ov);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_drain: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  // Signed overflow, carry, zero result and non-canonical codes.
  task automatic test_flags();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 16'h7FFF;
    y         = 16'h0001;
    ctrl      = 6'b000010;
    tick();
    checks++;
    if (out !== 16'h8000 || {zr, ng, cy, ov} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL ovf: got out=%h zr/ng/cy/ov=%b%b%b%b, expected 8000 0101", out, zr, ng, cy, ov);
    end
    // x - y via ~(~x + y)
    x    = 16'd5;
    y    = 16'd5;
    ctrl = 6'b010011;
    tick();
    checks++;
    if (out !== 16'h0000 || {zr, ng, cy, ov} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL sub_zero: got out=%h zr/ng/cy/ov=%b%b%b%b, expected 0000 1000", out, zr, ng, cy, ov);
    end
    x    = 16'hFFFF;
    y    = 16'h0001;
    ctrl = 6'b000010;
    tick();
    checks++;
    if (out !== 16'h0000 || {zr, ng, cy, ov} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL carry: got out=%h zr/ng/cy/ov=%b%b%b%b, expected 0000 1010", out, zr, ng, cy, ov);
    end
    // Plain AND
    x    = 16'h00F0;
    y    = 16'h0FF0;
    ctrl = 6'b000000;
    tick();
    checks++;
    if (out !== 16'h00F0 || {zr, ng, cy, ov} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL and: got out=%h zr/ng/cy/ov=%b%b%b%b, expected 00F0 0000", out, zr, ng, cy, ov);
    end
    // Non-canonical: x2 = all ones, AND with y, inverted -> ~y
    x    = 16'hAAAA;
    y    = 16'h1234;
    ctrl = 6'b110001;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 16'hEDCB || {zr, ng, cy, ov} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL noncanon: got out=%h zr/ng/cy/ov=%b%b%b%b, expected EDCB 0100", out, zr, ng, cy, ov);
    end
    tick();
  endtask

  // Output held under back-pressure, then A and B delivered in order.
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mul    = 1'b0;
    x         = 16'd1;
    y         = 16'd1;
    ctrl      = 6'b000010;
    tick();
    x = 16'd2;
    y = 16'd2;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0002 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_first: got valid=%b out=%h in_ready=%b, expected 1 0002 0", out_valid, out, in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0002 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_hold: got valid=%b out=%h in_ready=%b, expected 1 0002 0", out_valid, out, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_ready_comb: got in_ready=%b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL bp_second: got valid=%b out=%h, expected 1 0004", out_valid, out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  // One op per cycle, no bubbles.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 16'd10;
    y         = 16'd20;
    ctrl      = 6'b000010;
    tick();
    checks++;
    if (out !== 16'd30 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_0: got out=%h valid=%b in_ready=%b, expected 001e 1 1", out, out_valid, in_ready);
    end
    x    = 16'h1234;
    y    = 16'h5555;
    ctrl = 6'b001100;
    tick();
    checks++;
    if (out !== 16'h1234 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_1: got out=%h valid=%b, expected 1234 1", out, out_valid);
    end
    // y - x via ~(x + ~y)
    x    = 16'd3;
    y    = 16'd10;
    ctrl = 6'b000111;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out !== 16'd7 || out_valid !== 1'b1 || cy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_2: got out=%h valid=%b cy=%b, expected 0007 1 0", out, out_valid, cy);
    end
    tick();
  endtask

`ifdef ALU_MUL_EN
  // 300 * 300 = 0x15F90: in_ready low 17 cycles, result at accept+17.
  task automatic test_mul();
    int low_cycles;
    int valid_at;
    low_cycles = 0;
    valid_at   = -1;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_mul     = 1'b1;
    x          = 16'd300;
    y          = 16'd300;
    ctrl       = 6'b000000;
    tick();
    in_valid = 1'b0;
    in_mul   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid === 1'b1) begin
        valid_at = k + 1;
        break;
      end
      if (in_ready === 1'b0) low_cycles++;
      tick();
    end
    checks++;
    if (valid_at !== 18) begin
      errors++;
      $display("[TB] FAIL mul_latency: got out_valid at accept+%0d, expected accept+17", valid_at - 1);
    end
    checks++;
    if (low_cycles !== 17) begin
      errors++;
      $display("[TB] FAIL mul_busy: got in_ready low %0d cycles, expected 17", low_cycles);
    end
    checks++;
    if (out !== 16'h5F90 || {zr, ng, cy, ov} !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL mul_result: got out=%h zr/ng/cy/ov=%b%b%b%b, expected 5F90 0010", out, zr, ng, cy, ov);
    end
    tick();
  endtask
`else
  // Without the multiplier in_mul is ignored: plain latency-1 ALU op.
  task automatic test_mul();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mul    = 1'b1;
    x         = 16'd300;
    y         = 16'd300;
    ctrl      = 6'b000010;
    tick();
    in_valid = 1'b0;
    in_mul   = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'd600 || cy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_ignored: got valid=%b out=%h cy=%b, expected 1 0258 0", out_valid, out, cy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mul_ignored_ready: got in_ready=%b, expected 1", in_ready);
    end
    tick();
  endtask
`endif

  // Reset in the middle of an operation, then resume normally.
  task automatic test_reset_mid_op();
    int stray;
    stray    = 0;
    in_valid = 1'b1;
    x        = 16'd300;
    y        = 16'd300;
    ctrl     = 6'b000010;
`ifdef ALU_MUL_EN
    in_mul    = 1'b1;
    out_ready = 1'b1;
`else
    in_mul    = 1'b0;
    out_ready = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    in_mul   = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got valid=%b in_ready=%b out=%h, expected 0 0 0000", out_valid, in_ready, out);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (stray !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_abort: got %0d stray valid cycles in_ready=%b, expected 0 1", stray, in_ready);
    end
    in_valid = 1'b1;
    x        = 16'd2;
    y        = 16'd2;
    ctrl     = 6'b000010;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL midrst_resume: got valid=%b out=%h, expected 1 0004", out_valid, out);
    end
    tick();
  endtask

  // Narrow datapath: sign bit and overflow move to bit 7.
  task automatic test_width8();
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    x8         = 8'h7F;
    y8         = 8'h01;
    ctrl8      = 6'b000010;
    tick();
    checks++;
    if (out_valid8 !== 1'b1 || out8 !== 8'h80 || {zr8, ng8, cy8, ov8} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL w8_ovf: got valid=%b out=%h zr/ng/cy/ov=%b%b%b%b, expected 1 80 0101", out_valid8, out8, zr8, ng8, cy8, ov8);
    end
    ctrl8 = 6'b101010;
    tick();
    in_valid8 = 1'b0;
    checks++;
    if (out8 !== 8'h00 || {zr8, ng8, cy8, ov8} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL w8_zero: got out=%h zr/ng/cy/ov=%b%b%b%b, expected 00 1000", out8, zr8, ng8, cy8, ov8);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_mul();
    test_reset_mid_op();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
